// File: rtl/lf_track_pkg.sv
// ============================================================================
// Module  : lf_track_pkg
// Brief   : Shared types, default sizes and helpers for the low-frequency
//           hit tracking loop controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lf_track_pkg;

  // Default build-time sizes for the tracking loop
  localparam int C_CODE_W     = 6;
  localparam int C_CNT_W      = 8;
  localparam int C_WIN_LEN    = 64;
  localparam int C_SETTLE_LEN = 16;
  localparam int C_LOCK_WINS  = 4;

  // Controller states; the encodings are fixed so that debug taps and
  // legacy register views decode them identically.
  typedef enum logic [1:0] {
    LF_IDLE   = 2'd0,
    LF_COUNT  = 2'd1,
    LF_DECIDE = 2'd2,
    LF_SETTLE = 2'd3
  } lf_state_e;

  // Saturating +1 / -1 step clamped to [0, max_val]; 'up' wins over 'dn'.
  function automatic int unsigned sat_step(input int unsigned val,
                                           input int unsigned max_val,
                                           input logic        up,
                                           input logic        dn);
    if (up) begin
      return (val >= max_val) ? max_val : val + 32'd1;
    end else if (dn) begin
      return (val == 32'd0) ? 32'd0 : val - 32'd1;
    end else begin
      return val;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/lf_hit_sync.sv
// ============================================================================
// Module  : lf_hit_sync
// Brief   : Two-flop synchroniser for an asynchronous level flag, followed
//           by a delay flop and a single-cycle rising-edge pulse.
//           Usable for any slow asynchronous sampler flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lf_hit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta_q;   // first stage, may go metastable
  logic sync_q;   // synchronised level
  logic dly_q;    // synchronised level delayed one cycle

  // Synchroniser chain plus delay stage; runs regardless of controller state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign rise_pulse = sync_q & ~dly_q;

endmodule

`default_nettype wire

// File: rtl/lf_hit_track_ctrl.sv
// ============================================================================
// Module  : lf_hit_track_ctrl
// Brief   : Coarse frequency loop controller. Counts synchronised hit events
//           over fixed windows, compares the count with a target band and
//           steps the oscillator code up/down, then settles before the next
//           window.
//           Optional lock detector: define LF_TRACK_LOCK_DETECT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lf_hit_track_ctrl
  import lf_track_pkg::*;
#(
  parameter int CODE_W     = C_CODE_W,
  parameter int CNT_W      = C_CNT_W,
  parameter int WIN_LEN    = C_WIN_LEN,
  parameter int SETTLE_LEN = C_SETTLE_LEN,
  parameter int LOCK_WINS  = C_LOCK_WINS
) (
  input  logic              aux_clk,
  input  logic              rstb,
  input  logic              hit,
  input  logic              en,
  input  logic [CNT_W-1:0]  tgt_lo,
  input  logic [CNT_W-1:0]  tgt_hi,
  input  logic [CODE_W-1:0] code_init,
  output logic [CODE_W-1:0] osc_code,
  output logic              code_vld,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              busy,
  output logic              locked
);

  localparam logic [1:0] ST_IDLE   = 2'(LF_IDLE);
  localparam logic [1:0] ST_COUNT  = 2'(LF_COUNT);
  localparam logic [1:0] ST_DECIDE = 2'(LF_DECIDE);
  localparam logic [1:0] ST_SETTLE = 2'(LF_SETTLE);

  // One timer serves both the window and the settle interval
  localparam int TMR_MAX = (WIN_LEN > SETTLE_LEN) ? WIN_LEN : SETTLE_LEN;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WIN_LEN - 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_LEN - 1);

  localparam int unsigned CNT_MAX  = (32'd1 << CNT_W) - 32'd1;
  localparam int unsigned CODE_MAX = (32'd1 << CODE_W) - 32'd1;

  // Elaboration-time guard against unusable sizing
  if (WIN_LEN < 2 || SETTLE_LEN < 1 || LOCK_WINS < 1) begin : g_param_check
    $error("lf_hit_track_ctrl: WIN_LEN>=2, SETTLE_LEN>=1, LOCK_WINS>=1 required");
  end

  logic [1:0]        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  acc_q, acc_d;          // running count of current window
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;  // count of last completed window
  logic [CODE_W-1:0] osc_code_q, osc_code_d;
  logic              code_vld_q, code_vld_d;

  logic              hit_ev;
  logic [CNT_W-1:0]  acc_inc;
  logic              step_up;
  logic              step_dn;
  logic [CODE_W-1:0] code_next;

  lf_hit_sync u_hit_sync (
    .clk        (aux_clk),
    .rst_n      (rstb),
    .async_in   (hit),
    .rise_pulse (hit_ev)
  );

  // Band comparison; the low-side check wins so a misprogrammed band
  // (tgt_lo > tgt_hi) still drives the code upwards rather than oscillating.
  always_comb begin
    step_up   = (hit_cnt_q < tgt_lo);
    step_dn   = !step_up && (hit_cnt_q > tgt_hi);
    code_next = CODE_W'(sat_step(32'(osc_code_q), CODE_MAX, step_up, step_dn));
    acc_inc   = CNT_W'(sat_step(32'(acc_q), CNT_MAX, hit_ev, 1'b0));
  end

  // Controller sequencing: IDLE -> COUNT -> DECIDE -> SETTLE -> COUNT ...
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    acc_d      = acc_q;
    hit_cnt_d  = hit_cnt_q;
    osc_code_d = osc_code_q;
    code_vld_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          osc_code_d = code_init;
          tmr_d      = '0;
          acc_d      = '0;
          state_d    = ST_COUNT;
        end
      end
      ST_COUNT: begin
        // An event in the final window cycle still makes it into hit_cnt
        acc_d = acc_inc;
        if (tmr_q == WIN_LAST) begin
          hit_cnt_d = acc_inc;
          tmr_d     = '0;
          state_d   = ST_DECIDE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_DECIDE: begin
        osc_code_d = code_next;
        code_vld_d = (code_next != osc_code_q);
        tmr_d      = '0;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Events here are deliberately dropped: the oscillator is still moving
        if (tmr_q == SET_LAST) begin
          acc_d   = '0;
          tmr_d   = '0;
          state_d = ST_COUNT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disable aborts any activity; the partial window is thrown away but the
    // last completed count and the current code are kept.
    if (!en && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      tmr_d      = '0;
      acc_d      = acc_q;
      hit_cnt_d  = hit_cnt_q;
      osc_code_d = osc_code_q;
      code_vld_d = 1'b0;
    end
  end

  // Controller state registers
  always_ff @(posedge aux_clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      acc_q      <= '0;
      hit_cnt_q  <= '0;
      osc_code_q <= '0;
      code_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      acc_q      <= acc_d;
      hit_cnt_q  <= hit_cnt_d;
      osc_code_q <= osc_code_d;
      code_vld_q <= code_vld_d;
    end
  end

  assign osc_code = osc_code_q;
  assign code_vld = code_vld_q;
  assign hit_cnt  = hit_cnt_q;
  assign busy     = (state_q != ST_IDLE);

`ifdef LF_TRACK_LOCK_DETECT_EN
  localparam int               LCK_W    = $clog2(LOCK_WINS + 1);
  localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_WINS);

  logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;

  // Count consecutive in-band decisions; any out-of-band decision or a
  // disable restarts the count.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!en) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (state_q == ST_DECIDE) begin
      if (!step_up && !step_dn) begin
        lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + LCK_W'(1);
        locked_d   = (lock_cnt_d == LOCK_MAX);
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  // Lock detector registers
  always_ff @(posedge aux_clk or negedge rstb) begin
    if (!rstb) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lf_hit_track_ctrl.sv
// ============================================================================
// Module  : tb_lf_hit_track_ctrl
// Brief   : Self-checking bench for lf_hit_track_ctrl. A schedule-based model
//           predicts the outputs every cycle; directed scenarios add literal
//           expectations, followed by randomized enable/hit/target traffic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lf_hit_track_ctrl;

  localparam int CODE_W     = 6;
  localparam int CNT_W      = 8;
  localparam int WIN_LEN    = 64;
  localparam int SETTLE_LEN = 16;
  localparam int LOCK_WINS  = 4;
  localparam int PERIOD     = WIN_LEN + 1 + SETTLE_LEN;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int CODE_MAX   = (1 << CODE_W) - 1;
  localparam int SAT_WIN    = 1300;
`ifdef LF_TRACK_LOCK_DETECT_EN
  localparam int LOCK_ON = 1;
`else
  localparam int LOCK_ON = 0;
`endif

  logic              aux_clk = 1'b0;
  logic              rstb    = 1'b0;
  logic              hit     = 1'b0;
  logic              en      = 1'b0;
  logic [CNT_W-1:0]  tgt_lo  = '0;
  logic [CNT_W-1:0]  tgt_hi  = '0;
  logic [CODE_W-1:0] code_init = '0;
  logic [CODE_W-1:0] osc_code;
  logic              code_vld;
  logic [CNT_W-1:0]  hit_cnt;
  logic              busy;
  logic              locked;

  logic              hit2 = 1'b0;
  logic              en2  = 1'b0;
  logic [CODE_W-1:0] osc_code2;
  logic              code_vld2;
  logic [CNT_W-1:0]  hit_cnt2;
  logic              busy2;
  logic              locked2;

  int n_checks = 0;
  int n_pass   = 0;
  int vld_cnt  = 0;

  lf_hit_track_ctrl #(
    .CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN),
    .SETTLE_LEN(SETTLE_LEN), .LOCK_WINS(LOCK_WINS)
  ) dut (
    .aux_clk(aux_clk), .rstb(rstb), .hit(hit), .en(en),
    .tgt_lo(tgt_lo), .tgt_hi(tgt_hi), .code_init(code_init),
    .osc_code(osc_code), .code_vld(code_vld), .hit_cnt(hit_cnt),
    .busy(busy), .locked(locked)
  );

  // Long-window instance used only to reach hit counter saturation
  lf_hit_track_ctrl #(
    .CODE_W(CODE_W), .CNT_W(CNT_W), .WIN_LEN(SAT_WIN),
    .SETTLE_LEN(2), .LOCK_WINS(LOCK_WINS)
  ) dut_sat (
    .aux_clk(aux_clk), .rstb(rstb), .hit(hit2), .en(en2),
    .tgt_lo(tgt_lo), .tgt_hi(tgt_hi), .code_init(code_init),
    .osc_code(osc_code2), .code_vld(code_vld2), .hit_cnt(hit_cnt2),
    .busy(busy2), .locked(locked2)
  );

  always #5 aux_clk = ~aux_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge aux_clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model. Time is measured in edges since the loop started;
  // each PERIOD-long frame is WIN_LEN counting edges, one decision edge and
  // SETTLE_LEN settle edges. A rising level of 'hit' driven just after edge
  // n is seen as an event at edge n+3.
  // ---------------------------------------------------------------------
  bit       m_run;
  int       m_t, m_acc, m_code, m_cnt, m_lockn, ph;
  bit       m_vld, m_locked, ev;
  bit [3:0] hq;

  always @(posedge aux_clk) begin
    if (!rstb) begin
      m_run = 0; m_t = 0; m_acc = 0; m_code = 0; m_cnt = 0;
      m_vld = 0; m_lockn = 0; m_locked = 0; hq = '0;
    end else begin
      ev = hq[1] & ~hq[2];
      hq = {hq[2:0], hit};
      m_vld = 0;
      if (!m_run) begin
        if (en) begin
          m_run = 1; m_t = 0; m_acc = 0; m_code = int'(code_init);
        end
      end else if (!en) begin
        m_run = 0; m_lockn = 0; m_locked = 0;
      end else begin
        ph = m_t % PERIOD;
        if (ph < WIN_LEN) begin
          if (ev && m_acc < CNT_MAX) m_acc++;
          if (ph == WIN_LEN - 1) m_cnt = m_acc;
        end else if (ph == WIN_LEN) begin
          int nc;
          bit inb;
          inb = 0;
          if (m_cnt < int'(tgt_lo))      nc = (m_code == CODE_MAX) ? CODE_MAX : m_code + 1;
          else if (m_cnt > int'(tgt_hi)) nc = (m_code == 0) ? 0 : m_code - 1;
          else begin nc = m_code; inb = 1; end
          m_vld  = (nc != m_code);
          m_code = nc;
          if (LOCK_ON == 1) begin
            if (inb) m_lockn = (m_lockn >= LOCK_WINS) ? LOCK_WINS : m_lockn + 1;
            else     m_lockn = 0;
            m_locked = (m_lockn >= LOCK_WINS);
          end
        end else if (ph == PERIOD - 1) begin
          m_acc = 0;
        end
        m_t++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge aux_clk) begin
    logic [31:0] e_code, e_cnt;
    logic        e_vld, e_busy, e_lock;
    if (rstb) begin
      e_code = 32'(m_code); e_cnt = 32'(m_cnt);
      e_vld = m_vld; e_busy = m_run; e_lock = m_locked;
    end else begin
      e_code = '0; e_cnt = '0; e_vld = 1'b0; e_busy = 1'b0; e_lock = 1'b0;
    end
    check("m_osc_code", 32'(osc_code), e_code);
    check("m_hit_cnt",  32'(hit_cnt),  e_cnt);
    check("m_code_vld", 32'(code_vld), 32'(e_vld));
    check("m_busy",     32'(busy),     32'(e_busy));
    check("m_locked",   32'(locked),   32'(e_lock));
    if (code_vld === 1'b1) vld_cnt++;
  end

  // One decision period of hits: n hits every sp cycles from the window
  // start, an optional single hit at index 'one', optional hits in SETTLE.
  task automatic run_period(input int n, input int sp, input int one, input bit settle_hits);
    for (int i = 0; i < PERIOD; i++) begin
      hit = ((i < n * sp) && (i % sp == 0)) || (i == one) ||
            (settle_hits && (i == 66 || i == 70 || i == 74));
      tick();
    end
  endtask

  int v0, len, dens;

  initial begin
    // Reset and start
    tgt_lo = 8'd10; tgt_hi = 8'd14; code_init = 6'd20;
    repeat (3) tick();
    check("rst_osc_code", 32'(osc_code), 0);
    check("rst_hit_cnt",  32'(hit_cnt), 0);
    check("rst_busy",     32'(busy), 0);
    check("rst_locked",   32'(locked), 0);
    rstb = 1'b1; tick();
    en = 1'b1; tick();
    check("start_osc_code", 32'(osc_code), 20);
    check("start_busy",     32'(busy), 1);
    check("start_code_vld", 32'(code_vld), 0);

    // Low count: 5 hits per window -> step up each decision
    v0 = vld_cnt;
    for (int k = 0; k < 2; k++) begin
      run_period(5, 10, -1, 1'b0);
      check("low_osc_code", 32'(osc_code), 32'(21 + k));
      check("low_hit_cnt",  32'(hit_cnt), 5);
    end
    check("low_vld_pulses", 32'(vld_cnt - v0), 2);
    en = 1'b0; tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_osc_code", 32'(osc_code), 22);

    // High count with saturation at zero
    code_init = 6'd1; en = 1'b1; tick();
    v0 = vld_cnt;
    for (int k = 0; k < 3; k++) begin
      run_period(30, 2, -1, 1'b0);
      check("high_osc_code", 32'(osc_code), 0);
      check("high_hit_cnt",  32'(hit_cnt), 30);
    end
    check("high_vld_pulses", 32'(vld_cnt - v0), 1);
    en = 1'b0; tick();

    // Saturation high, then in-band lock, then one high window
    code_init = 6'd63; en = 1'b1; tick();
    v0 = vld_cnt;
    for (int k = 0; k < 2; k++) begin
      run_period(0, 2, -1, 1'b0);
      check("sathi_osc_code", 32'(osc_code), 63);
    end
    check("sathi_vld_pulses", 32'(vld_cnt - v0), 0);
    for (int k = 0; k < 4; k++) begin
      run_period(12, 2, -1, 1'b0);
      check("band_osc_code", 32'(osc_code), 63);
      if (k == 2) check("lock_not_yet", 32'(locked), 0);
    end
    check("lock_set", 32'(locked), 32'(LOCK_ON));
    run_period(20, 2, -1, 1'b0);
    check("unlock_osc_code", 32'(osc_code), 62);
    check("unlock_locked",   32'(locked), 0);
    check("unlock_hit_cnt",  32'(hit_cnt), 20);
    en = 1'b0; tick();

    // Window boundaries: last-cycle hit counted, settle/decide hits not
    tgt_lo = 8'd0; tgt_hi = 8'd5; code_init = 6'd30; en = 1'b1; tick();
    run_period(0, 2, 61, 1'b1);
    check("last_cycle_hit", 32'(hit_cnt), 1);
    run_period(0, 2, -1, 1'b0);
    check("settle_hits_ignored", 32'(hit_cnt), 0);
    run_period(0, 2, 62, 1'b0);
    check("decide_hit_ignored", 32'(hit_cnt), 0);
    run_period(0, 2, -1, 1'b0);
    check("edge_lock", 32'(locked), 32'(LOCK_ON));

    // Disable mid-COUNT
    for (int i = 0; i < 30; i++) begin
      hit = (i % 4 == 0);
      tick();
    end
    en = 1'b0; hit = 1'b0; tick();
    check("abort_busy",     32'(busy), 0);
    check("abort_osc_code", 32'(osc_code), 30);
    check("abort_hit_cnt",  32'(hit_cnt), 0);
    check("abort_locked",   32'(locked), 0);

    // Reset asserted mid-SETTLE clears outputs immediately
    tgt_lo = 8'd10; tgt_hi = 8'd14; code_init = 6'd40; en = 1'b1; tick();
    run_period(0, 2, -1, 1'b0);
    repeat (70) tick();
    rstb = 1'b0;
    #2;
    check("arst_osc_code", 32'(osc_code), 0);
    check("arst_hit_cnt",  32'(hit_cnt), 0);
    check("arst_busy",     32'(busy), 0);
    check("arst_locked",   32'(locked), 0);
    tick(); tick();
    rstb = 1'b1; en = 1'b0; tick();

    // Randomized traffic against the model
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        tgt_lo = 8'd0; tgt_hi = 8'd255;
      end else begin
        tgt_lo = 8'($urandom_range(0, 30));
        tgt_hi = 8'($urandom_range(0, 30));
      end
      code_init = 6'($urandom_range(0, 63));
      len  = $urandom_range(40, 500);
      dens = $urandom_range(1, 6);
      en = 1'b1;
      for (int i = 0; i < len; i++) begin
        hit = ($urandom_range(0, dens) == 0);
        tick();
      end
      en = 1'b0; hit = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    // Hit counter saturation: 300 events in one long window
    en2 = 1'b1; tick();
    for (int j = 0; j < 300; j++) begin
      hit2 = 1'b1; tick(); tick();
      hit2 = 1'b0; tick(); tick();
    end
    repeat (SAT_WIN - 1200 + 5) tick();
    check("sat_hit_cnt", 32'(hit_cnt2), 255);
    en2 = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lf_hit_track_ctrl.md
Name: lf_hit_track_ctrl

Overview:
- Consumes the asynchronous `hit` flag from the dual-edge sampler in the low-frequency tracking loop.
- Synchronises `hit` into the `aux_clk` domain and counts hit events over fixed measurement windows.
- Compares each window's count against a programmable target band and steps the oscillator control code up or down, with a settle interval after each decision.
- Sits between the sampler and the oscillator code input; closes the coarse frequency loop.

Parameters:
- CODE_W, 6: width of the oscillator control code.
- CNT_W, 8: width of the hit counter and target thresholds.
- WIN_LEN, 64: measurement window length in `aux_clk` cycles (>=2).
- SETTLE_LEN, 16: cycles to wait after a code decision before the next window (>=1).
- LOCK_WINS, 4: consecutive in-band windows required for lock (optional feature only).

Ports:
- aux_clk  in  1  sole clock.
- rstb  in  1  asynchronous active-low reset.
- hit  in  1  asynchronous hit flag from the sampler; not related to aux_clk.
- en  in  1  loop enable, synchronous.
- tgt_lo  in  CNT_W  lower bound of the in-band hit count, inclusive.
- tgt_hi  in  CNT_W  upper bound of the in-band hit count, inclusive.
- code_init  in  CODE_W  code loaded when the loop starts.
- osc_code  out  CODE_W  oscillator control code, registered.
- code_vld  out  1  one-cycle pulse when osc_code changes value.
- hit_cnt  out  CNT_W  hit count of the last completed window, registered.
- busy  out  1  high in every state except IDLE.
- locked  out  1  lock indicator (see Optional Feature).

Behaviour:
- Reset (rstb=0, asynchronous):
  - State goes to IDLE; all counters clear.
  - osc_code=0, hit_cnt=0, code_vld=0, busy=0, locked=0.
  - Synchroniser flops clear to 0.
- Synchroniser and edge detect:
  - hit passes through a 2-flop synchroniser to give hit_s, then one more delay flop to give hit_d.
  - hit_ev = hit_s & ~hit_d.
  - Total latency from hit to hit_ev is 2-3 cycles.
  - Synchroniser flops run in all states.
- IDLE:
  - osc_code holds its value.
  - When en=1, load osc_code<=code_init, clear the window and hit counters, and go to COUNT.
  - code_vld is not pulsed on this load.
- COUNT:
  - The window counter runs from 0 to WIN_LEN-1.
  - The hit counter increments on each hit_ev and saturates at 2^CNT_W-1 (no wrap).
  - An event that occurs in the last window cycle is counted.
  - After the last cycle, hit_cnt takes the final count and the FSM goes to DECIDE.
- DECIDE (exactly 1 cycle):
  - If hit_cnt < tgt_lo: osc_code+1, saturating at all-ones.
  - Else if hit_cnt > tgt_hi: osc_code-1, saturating at 0.
  - Otherwise hold.
  - The tgt_lo check has priority, which covers the misprogrammed case tgt_lo > tgt_hi.
  - The new osc_code is visible in the cycle after DECIDE.
  - code_vld pulses in that same cycle only if the value actually changed. A saturated step gives no pulse.
  - Go to SETTLE.
- SETTLE:
  - Counts SETTLE_LEN cycles. hit_ev is ignored.
  - Clears the hit counter, then goes to COUNT.
- en=0 in any non-IDLE state:
  - Go to IDLE on the next edge.
  - The in-progress window is discarded; hit_cnt keeps the last completed value.
  - osc_code is held; locked clears.
- Pipeline timing:
  - Decision-to-decision period is WIN_LEN+1+SETTLE_LEN cycles (81 with defaults).
  - First decision occurs WIN_LEN+1 cycles after leaving IDLE.

Optional Feature:
- Macro: LF_TRACK_LOCK_DETECT_EN.
- Defined:
  - A lock counter (width sufficient for LOCK_WINS) increments at each in-band DECIDE and saturates at LOCK_WINS.
  - locked=1 once the count reaches LOCK_WINS; it is registered and asserts the cycle after that DECIDE.
  - Any out-of-band DECIDE clears the counter and locked.
  - en=0 or reset clears both.
  - Code stepping is unaffected by lock.
- Undefined:
  - No lock logic is built; locked is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Package lf_track_pkg holds:
  - State enum with encodings IDLE=0, COUNT=1, DECIDE=2, SETTLE=3.
  - Default width and length constants.
  - A saturating inc/dec helper function.
- Sub-module lf_hit_sync contains the 2-flop synchroniser, delay flop and edge pulse. It is reusable for other async sampler flags.

Test Plan:
- Reset and start: reset, then en=1 with code_init=20.
  - osc_code=20 one cycle later, busy=1, code_vld=0.
  - All outputs 0 while rstb=0.
- Low count: tgt_lo=10, tgt_hi=14, inject 5 well-spaced hits per 64-cycle window.
  - hit_cnt=5, osc_code 20→21→22 on successive decisions spaced 81 cycles apart.
  - code_vld pulses once per step.
- High count and saturation low: 30 hits per window, code_init=1.
  - osc_code 1→0, then holds at 0.
  - No further code_vld pulses.
- Saturation high, in-band, lock: code_init=63 with 0 hits.
  - osc_code holds at 63 with no code_vld.
  - Then 12 hits per window: hold; with LF_TRACK_LOCK_DETECT_EN, locked=1 after the 4th window. One 20-hit window clears locked and steps the code down.
- Edge cases:
  - A hit in the last COUNT cycle is counted.
  - Hits during SETTLE are not counted.
  - A 300-event window saturates hit_cnt at 255.
  - Deasserting en mid-COUNT: IDLE next cycle, osc_code and the previous hit_cnt retained, locked=0.
  - Asserting rstb mid-SETTLE: immediate clear of all outputs.
